// File: rtl/weight_mem_loader.sv
// ---------------------------------------------------------------------------
// weight_mem_loader
//
// Write-side sequencer for the per-neuron weight memories of a fully
// connected layer. Accepts a valid/ready stream of fixed-point weights and
// turns each accepted word into a one-cycle write (wen/wadd/win) to the
// selected neuron's memory, filling addresses 0..numWeight-1. With load_all
// set, it rolls on through every following neuron up to numNeuron-1 with no
// bubble between neurons.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle load request, honoured only when idle
//   neuron_sel : first neuron to load (sampled with start)
//   load_all   : 1 = continue through the last neuron (sampled with start)
//   s_valid    : stream word valid
//   s_data     : stream weight
//   s_ready    : loader accepts a word this cycle
//   wen        : one-hot write enable, bit i = neuron memory i
//   wadd       : write address
//   win        : write data, bit-exact copy of the accepted word
//   busy       : request in progress (LOAD or DONE)
//   done       : one-cycle pulse when the whole request completes
//   err        : one-cycle pulse after a start with an out-of-range select
// ---------------------------------------------------------------------------
module weight_mem_loader #(
  parameter int numWeight    = 30,
  parameter int numNeuron    = 10,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight),
  parameter int neuronWidth  = $clog2(numNeuron)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [neuronWidth-1:0]  neuron_sel,
  input  logic                    load_all,
  input  logic                    s_valid,
  input  logic [dataWidth-1:0]    s_data,
  output logic                    s_ready,
  output logic [numNeuron-1:0]    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
  localparam logic [neuronWidth-1:0]  LAST_SEL  = neuronWidth'(numNeuron - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_beat;
  logic                    w_sel_ok;

  logic [neuronWidth-1:0]  r_sel;
  logic                    r_all;
  logic [addressWidth-1:0] r_addr;
  logic                    r_ready;
  logic [numNeuron-1:0]    r_wen;
  logic [addressWidth-1:0] r_wadd;
  logic [dataWidth-1:0]    r_win;
  logic                    r_err;

  assign w_sel_ok = (neuron_sel <= LAST_SEL);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // behaviour between always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode. r_ready drops on the final beat, so the cycle in LOAD
  // with r_ready low is the one where the last write is on the port; the FSM
  // moves to DONE only after that write has been presented.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_beat       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_sel_ok) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_beat = s_valid && r_ready;
        if (!r_ready) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: request capture, address/neuron sequencing and the registered
  // write port. wen defaults to zero every cycle so a write lasts exactly one
  // cycle; wadd/win simply hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_all   <= 1'b0;
      r_addr  <= '0;
      r_ready <= 1'b0;
      r_wen   <= '0;
      r_wadd  <= '0;
      r_win   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wen <= '0;
      r_err <= 1'b0;

      if (r_state == S_IDLE && start) begin
        if (w_sel_ok) begin
          r_sel   <= neuron_sel;
          r_all   <= load_all;
          r_addr  <= '0;
          r_ready <= 1'b1;
        end else begin
          r_err   <= 1'b1;
        end
      end

      if (w_beat) begin
        r_wen  <= numNeuron'(1) << r_sel;
        r_wadd <= r_addr;
        r_win  <= s_data;
        if (r_addr == LAST_ADDR) begin
          r_addr <= '0;
          // Chain straight into the next neuron; s_ready stays high so the
          // next word can be taken in the very next cycle.
          if (r_all && (r_sel != LAST_SEL)) begin
            r_sel <= r_sel + neuronWidth'(1);
          end else begin
            r_ready <= 1'b0;
          end
        end else begin
          r_addr <= r_addr + addressWidth'(1);
        end
      end
    end
  end

  assign s_ready = r_ready;
  assign wen     = r_wen;
  assign wadd    = r_wadd;
  assign win     = r_win;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;

endmodule

// File: tb/tb_weight_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_weight_mem_loader
//
// Directed self-checking bench for weight_mem_loader. Inputs are driven and
// outputs sampled on the falling edge; a posedge monitor logs every write
// (with its cycle number) into a queue and a model of the weight memories.
// ---------------------------------------------------------------------------
module tb_weight_mem_loader;

  localparam int NW   = 30;
  localparam int NN   = 10;
  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int NWID = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NWID-1:0] neuron_sel;
  logic            load_all;
  logic            s_valid;
  logic [DW-1:0]   s_data;
  logic            s_ready;
  logic [NN-1:0]   wen;
  logic [AW-1:0]   wadd;
  logic [DW-1:0]   win;
  logic            busy;
  logic            done;
  logic            err;

  typedef struct {
    logic [NN-1:0] wen;
    logic [AW-1:0] wadd;
    logic [DW-1:0] win;
    int            cyc;
  } wr_t;

  wr_t           wr_q[$];
  int            beat_q[$];
  logic [DW-1:0] mem [NN][NW];

  int cyc       = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int multi_hot = 0;
  int n_checks  = 0;
  int n_pass    = 0;

  weight_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .neuron_sel (neuron_sel),
    .load_all   (load_all),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .wen        (wen),
    .wadd       (wadd),
    .win        (win),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write/done monitor: values seen here are those held during the cycle
  // that this edge closes, i.e. the cycle in which the memory commits.
  always @(posedge clk) begin
    if (wen != '0) begin
      wr_q.push_back('{wen, wadd, win, cyc});
      if (!$onehot(wen)) multi_hot++;
      for (int i = 0; i < NN; i++) begin
        if (wen[i]) mem[i][wadd] = win;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [NWID-1:0] sel, input logic all);
    start      = 1'b1;
    neuron_sel = sel;
    load_all   = all;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + DW'(i) * step;
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Expected write i: neuron sel0 + i/NW, address i%NW, data base + i*step.
  task automatic check_log(input string tag, input int n, input int sel0,
                           input logic [DW-1:0] base, input logic [DW-1:0] step,
                           input bit consec);
    int            gaps;
    logic [NN-1:0] ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    gaps = 0;
    check({tag, "_count"}, wr_q.size(), n);
    for (int i = 0; i < wr_q.size() && i < n; i++) begin
      ew = NN'(1) << (sel0 + i / NW);
      ea = AW'(i % NW);
      ed = base + DW'(i) * step;
      check($sformatf("%s_wr%0d", tag, i), {wr_q[i].wen, wr_q[i].wadd, wr_q[i].win}, {ew, ea, ed});
      if (i > 0 && wr_q[i].cyc != wr_q[i-1].cyc + 1) gaps++;
    end
    if (consec) check({tag, "_gaps"}, gaps, 0);
  endtask

  initial begin
    int d0;
    int beats;
    int bad;
    int last_cyc;
    bit v;

    rst        = 1'b1;
    start      = 1'b0;
    neuron_sel = '0;
    load_all   = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NW; a++) mem[n][a] = '0;

    // Reset state
    repeat (2) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_wen", wen, 0);
    check("rst_wadd", wadd, 0);
    check("rst_win", win, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // Single neuron 3, back-to-back 0x0001..0x001E
    wr_q.delete();
    d0 = done_cnt;
    do_start(4'd3, 1'b0);
    check("single_ready", s_ready, 1);
    check("single_busy", busy, 1);
    feed(30, 16'h0001, 16'h0001);
    check("single_drain_ready", s_ready, 0);
    check("single_drain_done", done, 0);
    check("single_last_wen", wen, 10'h008);
    check("single_last_wadd", wadd, 29);
    tick();
    check("single_done", done, 1);
    check("single_done_busy", busy, 1);
    tick();
    check("single_done_end", done, 0);
    check("single_idle_busy", busy, 0);
    check("single_idle_ready", s_ready, 0);
    check_log("single", 30, 3, 16'h0001, 16'h0001, 1'b1);
    last_cyc = (wr_q.size() > 0) ? wr_q[wr_q.size()-1].cyc : -100;
    check("single_done_lat", done_cyc, last_cyc + 1);
    check("single_done_cnt", done_cnt - d0, 1);
    for (int k = 0; k < NW; k++) check($sformatf("mem3_%0d", k), mem[3][k], k + 1);

    // Stalled stream: random gaps, 0xF596 on every beat, filler otherwise
    wr_q.delete();
    beat_q.delete();
    d0    = done_cnt;
    beats = 0;
    do_start(4'd3, 1'b0);
    for (int c = 0; c < 400 && beats < 30; c++) begin
      v       = (c % 4 == 1) ? 1'b0 : (c % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_valid = v;
      s_data  = v ? 16'hF596 : 16'h1234;
      if (v) begin
        beat_q.push_back(cyc);
        beats++;
      end
      tick();
    end
    s_valid = 1'b0;
    s_data  = '0;
    check("stall_budget", beats, 30);
    repeat (3) tick();
    check_log("stall", 30, 3, 16'hF596, 16'h0000, 1'b0);
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < beat_q.size(); i++)
      if (wr_q[i].cyc != beat_q[i] + 1) bad++;
    check("stall_align", bad, 0);
    check("stall_done_cnt", done_cnt - d0, 1);

    // Chained load 8 -> 9, 60 words with sign bit set
    wr_q.delete();
    d0 = done_cnt;
    do_start(4'd8, 1'b1);
    feed(60, 16'h8000, 16'h0001);
    repeat (3) tick();
    check_log("chain", 60, 8, 16'h8000, 16'h0001, 1'b1);
    check("chain_done_cnt", done_cnt - d0, 1);
    check("chain_idle", busy, 0);

    // Illegal select
    wr_q.delete();
    do_start(4'd12, 1'b0);
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);
    check("illegal_ready", s_ready, 0);
    check("illegal_wen", wen, 0);
    tick();
    check("illegal_err_end", err, 0);
    check("illegal_busy2", busy, 0);
    check("illegal_writes", wr_q.size(), 0);

    // Start while busy (neuron 5), then start during DONE, then restart
    wr_q.delete();
    d0 = done_cnt;
    do_start(4'd5, 1'b0);
    for (int i = 0; i < 30; i++) begin
      s_valid    = 1'b1;
      s_data     = 16'h5000 + DW'(i);
      start      = (i == 3);
      neuron_sel = '0;
      load_all   = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b0;
    tick();
    check("busy_done", done, 1);
    start      = 1'b1;
    neuron_sel = 4'd1;
    load_all   = 1'b0;
    tick();
    start = 1'b0;
    check("done_start_busy", busy, 0);
    check("done_start_ready", s_ready, 0);
    check_log("busy", 30, 5, 16'h5000, 16'h0001, 1'b1);
    check("busy_done_cnt", done_cnt - d0, 1);
    wr_q.delete();
    do_start(4'd2, 1'b0);
    check("restart_busy", busy, 1);
    check("restart_ready", s_ready, 1);

    // Reset after beat 14 of a neuron-2 load
    feed(14, 16'h0A00, 16'h0001);
    tick();
    s_valid = 1'b1;
    s_data  = 16'h0A0E;
    rst     = 1'b1;
    #1;
    check("midrst_wen", wen, 0);
    check("midrst_ready", s_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wadd", wadd, 0);
    check("midrst_win", win, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    s_valid = 1'b0;
    tick();
    check_log("midrst", 14, 2, 16'h0A00, 16'h0001, 1'b1);
    check("midrst_mem13", mem[2][13], 16'h0A0D);
    check("midrst_mem14", mem[2][14], 16'h0000);

    wr_q.delete();
    d0 = done_cnt;
    do_start(4'd2, 1'b0);
    feed(30, 16'h0B00, 16'h0001);
    repeat (3) tick();
    check_log("reload", 30, 2, 16'h0B00, 16'h0001, 1'b1);
    check("reload_mem0", mem[2][0], 16'h0B00);
    check("reload_done_cnt", done_cnt - d0, 1);
    check("onehot", multi_hot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
